rr_fifo_enq_arbiter: RTL and testbench

- Shares one depth-1 output buffer (FULL_N/EMPTY_N/DEQ semantics) among NREQ enqueue requesters using round-robin arbitration.
- Grants are locked for multi-beat packets until the LAST beat is accepted.
- Sits in front of a single-consumer pipeline stage, e.g. the memory-request or writeback port shared by several core units.
- The output side connects directly to a consumer that dequeues with DEQ and allows same-cycle enqueue/dequeue.

---
 rtl/rr_fifo_enq_arbiter.sv | 84 ++++++++
 tb/tb_rr_fifo_enq_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/rr_fifo_enq_arbiter.sv
// rr_fifo_enq_arbiter: round-robin arbiter of NREQ enqueue ports into one depth-1 buffer,
// holding the grant on one requester until the last beat of its packet is accepted.
module rr_fifo_enq_arbiter #(
    parameter int width = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*width-1:0] D_IN,
    input  logic [NREQ-1:0]       LAST,
    output logic [NREQ-1:0]       GNT,
    input  logic                  CLR,
    output logic [width-1:0]      D_OUT,
    output logic [IDW-1:0]        SRC_ID,
    output logic                  LAST_OUT,
    output logic                  EMPTY_N,
    input  logic                  DEQ,
    output logic                  FULL_N,
    output logic                  LOCKED
);
    logic           valid, lock, any_hi, has_cand, take;
    logic [IDW-1:0] ptr, owner, lo, hi, cand;

    assign EMPTY_N = valid;
    assign LOCKED  = lock;
    assign FULL_N  = !valid || DEQ;

    // lo: lowest requester overall; hi: lowest requester above ptr (wrap falls back to lo)
    always_comb begin
        lo     = '0;
        hi     = '0;
        any_hi = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (REQ[i]) lo = IDW'(i);
            if (REQ[i] && i > int'(ptr)) begin
                hi     = IDW'(i);
                any_hi = 1'b1;
            end
        end
        cand     = lock ? owner : (any_hi ? hi : lo);
        has_cand = lock ? REQ[owner] : |REQ;
    end

    assign take = FULL_N && !CLR && !RST && has_cand;
    assign GNT  = take ? (NREQ'(1) << cand) : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid    <= 1'b0;
            D_OUT    <= '0;
            SRC_ID   <= '0;
            LAST_OUT <= 1'b0;
            lock     <= 1'b0;
            owner    <= '0;
            ptr      <= IDW'(NREQ - 1);
        end else if (CLR) begin
            valid <= 1'b0;
            lock  <= 1'b0;
        end else if (take) begin
            valid    <= 1'b1;
            D_OUT    <= D_IN[cand*width +: width];
            SRC_ID   <= cand;
            LAST_OUT <= LAST[cand];
            lock     <= !LAST[cand];
            if (LAST[cand]) ptr <= cand;
            else owner <= cand;
        end else if (DEQ) begin
            valid <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    logic [6:0] idle;
    always_ff @(posedge CLK) begin
        if (RST || !lock || REQ[owner]) idle <= '0;
        else if (idle != 7'd127) idle <= idle + 7'd1;
        if (idle == 7'd64) $warning("locked owner idle for more than 64 cycles");
        if (!RST && !CLR && DEQ && !valid) $warning("dequeue from empty");
        if (!$onehot0(GNT)) $warning("multiple grants");
    end
`endif
endmodule

// File: tb/tb_rr_fifo_enq_arbiter.sv
// tb_rr_fifo_enq_arbiter: directed vectors with hand-computed expectations.
module tb_rr_fifo_enq_arbiter;
    logic         CLK, RST, CLR, DEQ, LAST_OUT, EMPTY_N, FULL_N, LOCKED;
    logic [3:0]   REQ, LAST, GNT;
    logic [31:0]  din [4];
    logic [127:0] D_IN;
    logic [31:0]  D_OUT;
    logic [1:0]   SRC_ID;
    int           total = 0, bad = 0;

    assign D_IN = {din[3], din[2], din[1], din[0]};

    rr_fifo_enq_arbiter #(.width(32), .NREQ(4), .IDW(2)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .D_IN(D_IN), .LAST(LAST), .GNT(GNT),
        .CLR(CLR), .D_OUT(D_OUT), .SRC_ID(SRC_ID), .LAST_OUT(LAST_OUT),
        .EMPTY_N(EMPTY_N), .DEQ(DEQ), .FULL_N(FULL_N), .LOCKED(LOCKED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; CLR = 1'b0; DEQ = 1'b0; REQ = 4'b1111; LAST = 4'b1111;
        for (int i = 0; i < 4; i++) din[i] = 32'h1000_0000 + i;
        #1 check("gnt_in_rst", GNT, 4'b0000);
        tick; tick;
        RST = 1'b0; REQ = 4'b0000;
        #1;
        check("rst_empty", EMPTY_N, 0);
        check("rst_dout", D_OUT, 0);
        check("rst_src", SRC_ID, 0);
        check("rst_last", LAST_OUT, 0);
        check("rst_lock", LOCKED, 0);
        check("rst_fulln", FULL_N, 1);

        // single-beat rotation
        REQ = 4'b1111; DEQ = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1 check("rr_gnt", GNT, 4'b0001 << (k % 4));
            tick;
            check("rr_empty", EMPTY_N, 1);
            check("rr_src", SRC_ID, k % 4);
            check("rr_dout", D_OUT, 32'h1000_0000 + (k % 4));
        end
        REQ = 4'b0000; tick;

        // 3-beat packet from requester 2 with requester 0 waiting
        REQ = 4'b0101; LAST = 4'b0001; din[2] = 32'hAAAA_0001;
        #1 check("pk_gnt_a", GNT, 4'b0100);
        check("pk_lock_pre", LOCKED, 0);
        tick;
        check("pk_lock_a", LOCKED, 1);
        check("pk_dout_a", D_OUT, 32'hAAAA_0001);
        din[2] = 32'hBBBB_0002;
        #1 check("pk_gnt_b", GNT, 4'b0100);
        tick;
        check("pk_lock_b", LOCKED, 1);
        check("pk_dout_b", D_OUT, 32'hBBBB_0002);
        din[2] = 32'hCCCC_0003; LAST = 4'b0101;
        #1 check("pk_gnt_c", GNT, 4'b0100);
        tick;
        check("pk_lock_c", LOCKED, 0);
        check("pk_dout_c", D_OUT, 32'hCCCC_0003);
        check("pk_lastout", LAST_OUT, 1);
        #1 check("pk_gnt_next", GNT, 4'b0001);
        tick;
        check("pk_src_next", SRC_ID, 0);

        // backpressure then same-cycle dequeue/enqueue
        DEQ = 1'b0; REQ = 4'b0010; LAST = 4'b1111; din[1] = 32'h1111_2222;
        #1 check("bp_fulln", FULL_N, 0);
        check("bp_gnt", GNT, 4'b0000);
        tick;
        check("bp_hold", D_OUT, 32'h1000_0000);
        check("bp_empty", EMPTY_N, 1);
        DEQ = 1'b1;
        #1 check("bp_fulln_deq", FULL_N, 1);
        check("bp_gnt_deq", GNT, 4'b0010);
        tick;
        check("bp_empty2", EMPTY_N, 1);
        check("bp_dout2", D_OUT, 32'h1111_2222);
        check("bp_src2", SRC_ID, 1);
        REQ = 4'b0000; tick;

        // locked owner 3 idles while requester 0 waits
        REQ = 4'b1001; LAST = 4'b0111;
        #1 check("id_gnt3", GNT, 4'b1000);
        tick;
        check("id_lock", LOCKED, 1);
        REQ = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            #1 check("id_gnt_idle", GNT, 4'b0000);
            tick;
        end
        REQ = 4'b1001; LAST = 4'b1111;
        #1 check("id_gnt3_end", GNT, 4'b1000);
        tick;
        check("id_unlock", LOCKED, 0);
        #1 check("id_gnt0", GNT, 4'b0001);
        tick;

        // CLR mid-packet keeps ptr at 1
        REQ = 4'b0010;
        #1 check("cl_gnt1_single", GNT, 4'b0010);
        tick;
        LAST = 4'b1101;
        #1 check("cl_gnt1_pkt", GNT, 4'b0010);
        tick;
        check("cl_lock", LOCKED, 1);
        CLR = 1'b1; REQ = 4'b0101; DEQ = 1'b0; LAST = 4'b1111;
        #1 check("cl_gnt_clr", GNT, 4'b0000);
        tick;
        CLR = 1'b0;
        check("cl_empty", EMPTY_N, 0);
        check("cl_unlock", LOCKED, 0);
        din[2] = 32'hC1C2_C3C4;
        #1 check("cl_gnt2", GNT, 4'b0100);
        tick;
        check("cl_src2", SRC_ID, 2);

        // dequeue from empty leaves state alone
        REQ = 4'b0000; DEQ = 1'b1;
        tick;
        check("de_empty0", EMPTY_N, 0);
        tick;
        check("de_empty1", EMPTY_N, 0);
        check("de_dout", D_OUT, 32'hC1C2_C3C4);
        check("de_src", SRC_ID, 2);

        // reset while locked
        REQ = 4'b0010; LAST = 4'b1101;
        #1 check("rl_gnt1", GNT, 4'b0010);
        tick;
        check("rl_lock", LOCKED, 1);
        RST = 1'b1;
        tick;
        RST = 1'b0; REQ = 4'b1110; LAST = 4'b1111;
        check("rl_empty", EMPTY_N, 0);
        check("rl_dout", D_OUT, 0);
        check("rl_src", SRC_ID, 0);
        check("rl_lastout", LAST_OUT, 0);
        check("rl_unlock", LOCKED, 0);
        #1 check("rl_gnt_low", GNT, 4'b0010);
        tick;
        check("rl_src1", SRC_ID, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
